// File: rtl/dram_cache_mem_responder_pkg.sv
// Shared types, default widths and address/response helpers for the DRAM cache memory responder.
// The helper functions operate on the default widths below; the top-level parameters default to them.
package dram_rsp_pkg;

    localparam int DEF_ADDR_WIDTH   = 32;
    localparam int DEF_DATA_WIDTH   = 512;
    localparam int DEF_ID_WIDTH     = 4;
    localparam int DEF_TAG_SIZE     = 16;
    localparam int DEF_INDEX_WIDTH  = 8;
    localparam int DEF_OFFSET_WIDTH = 6;
    localparam int DEF_LATENCY      = 4;
    localparam int DEF_RQ_DEPTH     = 8;

    typedef struct packed {
        logic [DEF_ID_WIDTH-1:0]   id;
        logic [DEF_ADDR_WIDTH-1:0] addr;
        logic [3:0]                cnt;
    } req_entry_t;

    function automatic logic [DEF_INDEX_WIDTH-1:0] addr_idx(input logic [DEF_ADDR_WIDTH-1:0] addr);
        return addr[DEF_OFFSET_WIDTH +: DEF_INDEX_WIDTH];
    endfunction

    // Zero-extend first so a narrow address still yields a full-width tag field.
    function automatic logic [DEF_TAG_SIZE-2:0] addr_tag(input logic [DEF_ADDR_WIDTH-1:0] addr);
        return (DEF_TAG_SIZE-1)'({{DEF_TAG_SIZE{1'b0}}, addr} >> (DEF_OFFSET_WIDTH + DEF_INDEX_WIDTH));
    endfunction

    function automatic logic [DEF_TAG_SIZE+DEF_DATA_WIDTH-1:0] make_rdata(
        input logic                      valid,
        input logic [DEF_TAG_SIZE-2:0]   tag,
        input logic [DEF_DATA_WIDTH-1:0] data
    );
        return valid ? {1'b1, tag, data} : '0;
    endfunction

endpackage

// File: rtl/dram_cache_mem_responder_if.sv
// AR/R request-response channel, fill write port and perf-counter outputs of the memory responder.
interface dram_cache_mem_responder_if #(
    parameter int ADDR_WIDTH = dram_rsp_pkg::DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = dram_rsp_pkg::DEF_DATA_WIDTH,
    parameter int ID_WIDTH   = dram_rsp_pkg::DEF_ID_WIDTH,
    parameter int TAG_SIZE   = dram_rsp_pkg::DEF_TAG_SIZE
);
    logic [ID_WIDTH-1:0]            m_arid_i;
    logic [ADDR_WIDTH-1:0]          m_araddr_i;
    logic                           m_arvalid_i;
    logic                           m_arready_o;
    logic [ID_WIDTH-1:0]            m_rid_o;
    logic [TAG_SIZE+DATA_WIDTH-1:0] m_rdata_o;
    logic                           m_rvalid_o;
    logic                           m_rready_i;
    logic                           fill_valid_i;
    logic                           fill_ready_o;
    logic [ADDR_WIDTH-1:0]          fill_addr_i;
    logic [DATA_WIDTH-1:0]          fill_data_i;
    logic [31:0]                    rd_cnt_o;
    logic [31:0]                    fill_cnt_o;

    modport master (
        output m_arid_i, m_araddr_i, m_arvalid_i, m_rready_i,
        output fill_valid_i, fill_addr_i, fill_data_i,
        input  m_arready_o, m_rid_o, m_rdata_o, m_rvalid_o,
        input  fill_ready_o, rd_cnt_o, fill_cnt_o
    );

    modport slave (
        input  m_arid_i, m_araddr_i, m_arvalid_i, m_rready_i,
        input  fill_valid_i, fill_addr_i, fill_data_i,
        output m_arready_o, m_rid_o, m_rdata_o, m_rvalid_o,
        output fill_ready_o, rd_cnt_o, fill_cnt_o
    );

endinterface

// File: rtl/dram_cache_mem_responder_rsp_req_queue.sv
// In-order request FIFO; every entry counts down from LATENCY-1 and the head may launch at zero.
module rsp_req_queue
    import dram_rsp_pkg::*;
#(
    parameter int DEPTH   = DEF_RQ_DEPTH,
    parameter int LATENCY = DEF_LATENCY
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      push,
    input  logic [DEF_ID_WIDTH-1:0]   push_id,
    input  logic [DEF_ADDR_WIDTH-1:0] push_addr,
    input  logic                      pop,
    output req_entry_t                head,
    output logic                      head_ready,
    output logic                      full
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    req_entry_t       mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic             empty;
    logic             push_ok;
    logic             pop_ok;

    assign empty      = (count == '0);
    assign full       = (count == (PTR_W+1)'(DEPTH));
    assign head       = mem[rd_ptr];
    assign head_ready = !empty && (head.cnt == 4'd0);
    assign push_ok    = push && !full;
    assign pop_ok     = pop && !empty;

    // Free slots may also tick down; a push always reloads the counter.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (mem[i].cnt != 4'd0) begin
                mem[i].cnt <= mem[i].cnt - 4'd1;
            end
        end
        if (push_ok) begin
            mem[wr_ptr] <= '{id: push_id, addr: push_addr, cnt: 4'(LATENCY - 1)};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/dram_cache_mem_responder.sv
// DRAM stand-in: tag+data line array answering AR requests in order after a fixed latency.
// Optional perf counters are built when DRAM_RSP_PERF_CNT_EN is defined; otherwise tied to zero.
module dram_cache_mem_responder
    import dram_rsp_pkg::*;
#(
    parameter int ADDR_WIDTH   = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
    parameter int ID_WIDTH     = DEF_ID_WIDTH,
    parameter int TAG_SIZE     = DEF_TAG_SIZE,
    parameter int INDEX_WIDTH  = DEF_INDEX_WIDTH,
    parameter int OFFSET_WIDTH = DEF_OFFSET_WIDTH,
    parameter int LATENCY      = DEF_LATENCY,
    parameter int RQ_DEPTH     = DEF_RQ_DEPTH
) (
    input  logic                        clk,
    input  logic                        rst,
    dram_cache_mem_responder_if.slave   bus
);
    localparam int LINES = 2**INDEX_WIDTH;

    logic [DATA_WIDTH-1:0]          data_array [LINES];
    logic [TAG_SIZE-2:0]            tag_array  [LINES];
    logic [LINES-1:0]               line_valid;

    req_entry_t                     head;
    logic [ADDR_WIDTH-1:0]          head_addr;
    logic [INDEX_WIDTH-1:0]         head_idx;
    logic [INDEX_WIDTH-1:0]         fill_idx;
    logic                           head_ready;
    logic                           q_full;
    logic                           ar_hs;
    logic                           r_hs;
    logic                           launch;

    logic                           rsp_valid;
    logic [ID_WIDTH-1:0]            rsp_id;
    logic [TAG_SIZE+DATA_WIDTH-1:0] rsp_data;
    logic                           unused_bits;

    assign ar_hs     = bus.m_arvalid_i && !q_full;
    assign r_hs      = rsp_valid && bus.m_rready_i;
    assign launch    = head_ready && (!rsp_valid || bus.m_rready_i);
    assign head_addr = head.addr;
    assign head_idx  = addr_idx(head_addr);
    assign fill_idx  = addr_idx(bus.fill_addr_i);

    assign bus.m_arready_o  = !q_full;
    assign bus.m_rvalid_o   = rsp_valid;
    assign bus.m_rid_o      = rsp_id;
    assign bus.m_rdata_o    = rsp_data;
    assign bus.fill_ready_o = 1'b1;

    assign unused_bits = ^{head.cnt, bus.fill_addr_i[OFFSET_WIDTH-1:0]};

    rsp_req_queue #(
        .DEPTH   (RQ_DEPTH),
        .LATENCY (LATENCY)
    ) u_req_queue (
        .clk        (clk),
        .rst        (rst),
        .push       (ar_hs),
        .push_id    (bus.m_arid_i),
        .push_addr  (bus.m_araddr_i),
        .pop        (launch),
        .head       (head),
        .head_ready (head_ready),
        .full       (q_full)
    );

    // Launch reads the arrays before a same-cycle fill lands, so a colliding read sees the old line.
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_data  <= '0;
        end else if (launch) begin
            rsp_valid <= 1'b1;
            rsp_id    <= head.id;
            rsp_data  <= make_rdata(line_valid[head_idx], tag_array[head_idx], data_array[head_idx]);
        end else if (r_hs) begin
            rsp_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (bus.fill_valid_i) begin
            data_array[fill_idx] <= bus.fill_data_i;
            tag_array[fill_idx]  <= addr_tag(bus.fill_addr_i);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            line_valid <= '0;
        end else if (bus.fill_valid_i) begin
            line_valid[fill_idx] <= 1'b1;
        end
    end

`ifdef DRAM_RSP_PERF_CNT_EN
    logic [31:0] rd_cnt;
    logic [31:0] fill_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_cnt   <= '0;
            fill_cnt <= '0;
        end else begin
            if (r_hs)             rd_cnt   <= rd_cnt + 32'd1;
            if (bus.fill_valid_i) fill_cnt <= fill_cnt + 32'd1;
        end
    end

    assign bus.rd_cnt_o   = rd_cnt;
    assign bus.fill_cnt_o = fill_cnt;
`else
    assign bus.rd_cnt_o   = '0;
    assign bus.fill_cnt_o = '0;
`endif

endmodule

// File: tb/tb_dram_cache_mem_responder.sv
// Directed and random stimulus for dram_cache_mem_responder against a line-array/in-order-queue model.
module tb_dram_cache_mem_responder;
    localparam int LAT   = 4;
    localparam int DEPTH = 8;
    localparam int W     = 528;
`ifdef DRAM_RSP_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    dram_cache_mem_responder_if bus ();
    dram_cache_mem_responder dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {
        logic [3:0]   id;
        logic [7:0]   idx;
        logic [527:0] rdata;
    } exp_t;

    exp_t         exp_q[$];
    bit           mv [256];
    logic [14:0]  mt [256];
    logic [511:0] md [256];
    int           n_checks = 0;
    int           n_errors = 0;
    int           model_rd = 0;
    int           model_fill = 0;
    bit           last_ar_hs;

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] m_idx(input logic [31:0] a);
        return 8'((a >> 6) & 32'hFF);
    endfunction

    function automatic logic [14:0] m_tag(input logic [31:0] a);
        return 15'((a >> 14) & 32'h7FFF);
    endfunction

    function automatic logic [511:0] rnd_line();
        logic [511:0] l;
        for (int i = 0; i < 16; i++) l[i*32 +: 32] = $urandom;
        return l;
    endfunction

    function automatic logic [31:0] rnd_addr();
        return (32'($urandom_range(0, 7)) << 29) | (32'($urandom_range(0, 3)) << 14) |
               (32'($urandom_range(16, 19)) << 6) | 32'($urandom_range(0, 63));
    endfunction

    function automatic bit pending(input logic [31:0] a);
        foreach (exp_q[i]) if (exp_q[i].idx == m_idx(a)) return 1'b1;
        return 1'b0;
    endfunction

    // Drive one cycle at the negedge, update the model for the handshakes that will occur, advance.
    task automatic tick(input bit arv, input logic [31:0] ara, input logic [3:0] arid, input bit rr,
                        input bit fv, input logic [31:0] fa, input logic [511:0] fd);
        bit   ar_hs;
        bit   r_hs;
        exp_t e;
        bus.m_arvalid_i  = arv;
        bus.m_araddr_i   = ara;
        bus.m_arid_i     = arid;
        bus.m_rready_i   = rr;
        bus.fill_valid_i = fv;
        bus.fill_addr_i  = fa;
        bus.fill_data_i  = fd;
        ar_hs = arv && bus.m_arready_o;
        r_hs  = bus.m_rvalid_o && rr;
        last_ar_hs = ar_hs;
        if (!rst) begin
            if (r_hs) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_rsp", W'(bus.m_rvalid_o), W'(0));
                end else begin
                    e = exp_q.pop_front();
                    chk("rsp_id", W'(bus.m_rid_o), W'(e.id));
                    chk("rsp_data", bus.m_rdata_o, e.rdata);
                end
                model_rd++;
            end
            if (fv) begin
                mv[m_idx(fa)] = 1'b1;
                mt[m_idx(fa)] = m_tag(fa);
                md[m_idx(fa)] = fd;
                model_fill++;
            end
            if (ar_hs) begin
                e.id    = arid;
                e.idx   = m_idx(ara);
                e.rdata = mv[e.idx] ? {1'b1, mt[e.idx], md[e.idx]} : '0;
                exp_q.push_back(e);
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle(input bit rr);
        tick(1'b0, '0, '0, rr, 1'b0, '0, '0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle(1'b0);
        idle(1'b0);
        rst = 1'b0;
        exp_q.delete();
        for (int i = 0; i < 256; i++) mv[i] = 1'b0;
        model_rd   = 0;
        model_fill = 0;
    endtask

    task automatic drain();
        for (int k = 0; k < 60; k++) begin
            if (exp_q.size() == 0 && !bus.m_rvalid_o) break;
            idle(1'b1);
        end
        chk("drain_outstanding", W'(exp_q.size()), W'(0));
        chk("drain_rvalid", W'(bus.m_rvalid_o), W'(0));
    endtask

    task automatic wait_rvalid(output int cyc);
        cyc = 0;
        for (int k = 1; k <= 20; k++) begin
            idle(1'b0);
            if (bus.m_rvalid_o) begin
                cyc = k;
                break;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int           lat;
        int           acc;
        logic [511:0] line;
        bit           arv, rr, fv;
        logic [31:0]  ara, fa;

        bus.m_arvalid_i  = 1'b0;
        bus.m_araddr_i   = '0;
        bus.m_arid_i     = '0;
        bus.m_rready_i   = 1'b0;
        bus.fill_valid_i = 1'b0;
        bus.fill_addr_i  = '0;
        bus.fill_data_i  = '0;
        @(negedge clk);
        do_reset();

        chk("rst_arready", W'(bus.m_arready_o), W'(1));
        chk("rst_rvalid", W'(bus.m_rvalid_o), W'(0));
        chk("rst_rid", W'(bus.m_rid_o), W'(0));
        chk("rst_rdata", bus.m_rdata_o, W'(0));
        chk("rst_fill_ready", W'(bus.fill_ready_o), W'(1));
        chk("rst_rd_cnt", W'(bus.rd_cnt_o), W'(0));
        chk("rst_fill_cnt", W'(bus.fill_cnt_o), W'(0));

        // Read of a never-filled line, latency from acceptance
        tick(1'b1, 32'h0000_1240, 4'd3, 1'b0, 1'b0, '0, '0);
        wait_rvalid(lat);
        chk("latency", W'(lat), W'(LAT));
        chk("cold_rid", W'(bus.m_rid_o), W'(3));
        chk("cold_rdata", bus.m_rdata_o, W'(0));
        drain();

        // Fill then read the same address
        line = {64{8'hA5}};
        tick(1'b0, '0, '0, 1'b0, 1'b1, 32'h0001_2340, line);
        tick(1'b1, 32'h0001_2340, 4'd5, 1'b0, 1'b0, '0, '0);
        wait_rvalid(lat);
        chk("fill_hit_rdata", bus.m_rdata_o, {1'b1, 15'd4, line});
        drain();

        // Fill and launch to idx 0x49 on the same edge
        line = rnd_line();
        tick(1'b1, 32'h0000_1240, 4'd1, 1'b1, 1'b0, '0, '0);
        idle(1'b1);
        idle(1'b1);
        idle(1'b1);
        tick(1'b0, '0, '0, 1'b1, 1'b1, 32'h0001_D240, line);
        chk("collide_launch", W'(bus.m_rvalid_o), W'(1));
        chk("collide_old", bus.m_rdata_o, W'(0));
        tick(1'b1, 32'h0000_1240, 4'd2, 1'b1, 1'b0, '0, '0);
        wait_rvalid(lat);
        chk("collide_new", bus.m_rdata_o, {1'b1, 15'd7, line});
        drain();

        // Backpressure: queue plus response register absorb DEPTH+1 requests
        acc = 0;
        for (int k = 0; k < 20; k++) begin
            if (!bus.m_arready_o) break;
            tick(1'b1, rnd_addr(), 4'(acc), 1'b0, 1'b0, '0, '0);
            if (last_ar_hs) acc++;
        end
        chk("bp_accepted", W'(acc), W'(DEPTH + 1));
        chk("bp_arready_low", W'(bus.m_arready_o), W'(0));
        for (int i = 0; i <= DEPTH; i++) begin
            chk("bp_rvalid", W'(bus.m_rvalid_o), W'(1));
            chk("bp_id_order", W'(bus.m_rid_o), W'(i));
            idle(1'b1);
        end
        chk("bp_done", W'(bus.m_rvalid_o), W'(0));

        // Reset with requests outstanding
        for (int i = 0; i < 3; i++) tick(1'b1, rnd_addr(), 4'(i), 1'b0, 1'b0, '0, '0);
        do_reset();
        chk("midrst_arready", W'(bus.m_arready_o), W'(1));
        for (int k = 0; k < 8; k++) begin
            chk("midrst_no_rsp", W'(bus.m_rvalid_o), W'(0));
            idle(1'b1);
        end

        // Perf counters: 2 fills, 5 reads
        tick(1'b0, '0, '0, 1'b1, 1'b1, 32'h0000_0400, rnd_line());
        tick(1'b0, '0, '0, 1'b1, 1'b1, 32'h0000_4480, rnd_line());
        for (int i = 0; i < 5; i++) tick(1'b1, 32'(i) << 6, 4'(i + 8), 1'b1, 1'b0, '0, '0);
        drain();
        chk("cnt_rd", W'(bus.rd_cnt_o), PERF ? W'(model_rd) : W'(0));
        chk("cnt_fill", W'(bus.fill_cnt_o), PERF ? W'(model_fill) : W'(0));

        // Random traffic; fills avoid lines with reads in flight so accept-time content is exact
        for (int c = 0; c < 400; c++) begin
            arv = ($urandom_range(0, 99) < 60);
            ara = rnd_addr();
            rr  = ($urandom_range(0, 99) < 70);
            fv  = ($urandom_range(0, 99) < 25);
            fa  = rnd_addr();
            if (fv && pending(fa)) fv = 1'b0;
            tick(arv, ara, 4'($urandom), rr, fv, fa, rnd_line());
        end
        drain();
        chk("rand_rd_cnt", W'(bus.rd_cnt_o), PERF ? W'(model_rd) : W'(0));
        chk("rand_fill_cnt", W'(bus.fill_cnt_o), PERF ? W'(model_fill) : W'(0));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
